// File: rtl/ccip_mmio_regfile_if.sv
// CCI-P MMIO request/response fields plus the mapped-write stream toward the FPU.
// The regfile side uses the slave modport; the host/FPU side uses master.
interface ccip_mmio_regfile_if #(
  parameter int MAP_DATA_WIDTH = 32,
  parameter int MAP_ADDR_WIDTH = 32
);
  logic                      mmio_rd_valid;
  logic                      mmio_wr_valid;
  logic [15:0]               mmio_addr;
  logic [1:0]                mmio_len;
  logic [8:0]                mmio_tid;
  logic [63:0]               mmio_wr_data;
  logic                      mmio_rsp_valid;
  logic [8:0]                mmio_rsp_tid;
  logic [63:0]               mmio_rsp_data;
  logic                      mapped_data_valid;
  logic                      mapped_data_ready;
  logic [MAP_DATA_WIDTH-1:0] mapped_data;
  logic [MAP_ADDR_WIDTH-1:0] mapped_address;

  modport slave (
    input  mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_len, mmio_tid, mmio_wr_data,
    input  mapped_data_ready,
    output mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data,
    output mapped_data_valid, mapped_data, mapped_address
  );

  modport master (
    output mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_len, mmio_tid, mmio_wr_data,
    output mapped_data_ready,
    input  mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data,
    input  mapped_data_valid, mapped_data, mapped_address
  );
endinterface

// File: rtl/ccip_mmio_regfile.sv
// CCI-P MMIO register file: DFH/AFU_ID header, STATUS, NUM_REGS user registers,
// and a valid/ready FIFO forwarding every user-register write to the FPU.
module ccip_mmio_regfile #(
  parameter int             NUM_REGS       = 8,
  parameter logic [15:0]    USER_BASE      = 16'h0010,
  parameter int             FIFO_DEPTH     = 4,
  parameter int             MAP_DATA_WIDTH = 32,
  parameter int             MAP_ADDR_WIDTH = 32,
  parameter logic [127:0]   AFU_ID         = 128'h0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ccip_mmio_regfile_if.slave        bus,
  output logic [64*NUM_REGS-1:0]    reg_q
);

  localparam logic [63:0]    DFH      = 64'h1000_0100_0000_0000;
  localparam int             IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int             PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [63:0]               user_reg [NUM_REGS];
  logic [15:0]               drop_cnt;
  logic [PTR_W:0]            fifo_cnt;
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [IDX_W-1:0]          mem_idx  [FIFO_DEPTH];
  logic [MAP_DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];

  logic [14:0]      word_addr, user_off;
  logic [IDX_W-1:0] user_idx;
  logic             user_hit, acc_ok, wr_user, wr_status;
  logic [63:0]      word_val, rd_data_c, wr_merged, cur_val;

  assign word_addr = bus.mmio_addr[15:1];
  assign user_off  = word_addr - USER_BASE[15:1];
  assign user_hit  = (word_addr >= USER_BASE[15:1]) && (user_off < 15'(NUM_REGS));
  assign user_idx  = user_off[IDX_W-1:0];
  assign acc_ok    = (bus.mmio_len == 2'd0) || ((bus.mmio_len == 2'd1) && !bus.mmio_addr[0]);
  assign wr_user   = bus.mmio_wr_valid && acc_ok && user_hit;
  assign wr_status = bus.mmio_wr_valid && acc_ok && !user_hit && (word_addr == 15'h5);
  assign cur_val   = user_reg[user_idx];

  always_comb begin
    word_val = '0;
    if (user_hit) begin
      word_val = cur_val;
    end else begin
      case (word_addr)
        15'h0:   word_val = DFH;
        15'h1:   word_val = AFU_ID[63:0];
        15'h2:   word_val = AFU_ID[127:64];
        15'h5:   word_val = {40'd0, 8'(fifo_cnt), drop_cnt};
        default: word_val = '0;
      endcase
    end
  end

  // 4B accesses return the selected half right-justified; illegal shapes read 0.
  always_comb begin
    rd_data_c = '0;
    if ((bus.mmio_len == 2'd1) && !bus.mmio_addr[0])
      rd_data_c = word_val;
    else if (bus.mmio_len == 2'd0)
      rd_data_c = {32'd0, bus.mmio_addr[0] ? word_val[63:32] : word_val[31:0]};
  end

  always_comb begin
    wr_merged = bus.mmio_wr_data;
    if (bus.mmio_len == 2'd0)
      wr_merged = bus.mmio_addr[0] ? {bus.mmio_wr_data[31:0], cur_val[31:0]}
                                   : {cur_val[63:32], bus.mmio_wr_data[31:0]};
  end

  // p0: read captured from pre-write state; write data latched for the FIFO push
  logic                      vld_p0, vld_p1;
  logic [8:0]                tid_p0, tid_p1;
  logic [63:0]               data_p0, data_p1;
  logic                      push_vld_p0;
  logic [IDX_W-1:0]          push_idx_p0;
  logic [MAP_DATA_WIDTH-1:0] push_data_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0       <= 1'b0;
      tid_p0       <= '0;
      data_p0      <= '0;
      push_vld_p0  <= 1'b0;
      push_idx_p0  <= '0;
      push_data_p0 <= '0;
      for (int i = 0; i < NUM_REGS; i++) user_reg[i] <= '0;
    end else begin
      vld_p0       <= bus.mmio_rd_valid;
      tid_p0       <= bus.mmio_tid;
      data_p0      <= rd_data_c;
      push_vld_p0  <= wr_user;
      push_idx_p0  <= user_idx;
      push_data_p0 <= wr_merged[MAP_DATA_WIDTH-1:0];
      if (wr_user) user_reg[user_idx] <= wr_merged;
    end
  end

  // p1: registered read response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      tid_p1  <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= vld_p0;
      tid_p1  <= tid_p0;
      data_p1 <= data_p0;
    end
  end

  assign bus.mmio_rsp_valid = vld_p1;
  assign bus.mmio_rsp_tid   = tid_p1;
  assign bus.mmio_rsp_data  = data_p1;

  logic pop, full, push_ok, drop;
  assign pop     = (fifo_cnt != '0) && bus.mapped_data_ready;
  assign full    = (fifo_cnt == FULL_CNT);
  assign push_ok = push_vld_p0 && (!full || pop);
  assign drop    = push_vld_p0 && full && !pop;

  // A STATUS write in the same cycle as a drop must leave drop_cnt at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      drop_cnt <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_idx[k]  <= '0;
        mem_data[k] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_idx[wr_ptr]  <= push_idx_p0;
        mem_data[wr_ptr] <= push_data_p0;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (wr_status)  drop_cnt <= '0;
      else if (drop)  drop_cnt <= sat_inc16(drop_cnt);
    end
  end

  assign bus.mapped_data_valid = (fifo_cnt != '0);
  assign bus.mapped_data       = mem_data[rd_ptr];
  assign bus.mapped_address    = MAP_ADDR_WIDTH'(mem_idx[rd_ptr]);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[64*g +: 64] = user_reg[g];
  end

endmodule

// File: doc/ccip_mmio_regfile.md
Name: ccip_mmio_regfile

Overview:
- Parametrised CCI-P MMIO register file for the AFU top.
- Serves the DFH/AFU_ID feature header and a status register, plus NUM_REGS 64-bit user registers.
- Forwards every user-register write to the FPU as a mapped_address/mapped_data transaction through a valid/ready FIFO.
- Sits between the already-registered CCI-P MMIO request/response fields and the FPU mapped-data inputs.

Parameters:
- NUM_REGS, 8: number of 64-bit user registers.
- USER_BASE, 16'h0010: word address of user register 0. Must be even.
- FIFO_DEPTH, 4: depth of the mapped-write FIFO. Power of two, ≥2.
- MAP_DATA_WIDTH, 32: width of mapped_data. Must be ≤64.
- MAP_ADDR_WIDTH, 32: width of mapped_address.
- AFU_ID, 128'h0: value returned in the AFU_ID registers.

Ports:
- clk  in  1: sole clock.
- rst_n  in  1: asynchronous active-low reset.
- mmio_rd_valid  in  1: MMIO read request.
- mmio_wr_valid  in  1: MMIO write request.
- mmio_addr  in  16: 32-bit-word address (CCI-P convention).
- mmio_len  in  2: 0 = 4B, 1 = 8B, other = illegal.
- mmio_tid  in  9: read transaction ID.
- mmio_wr_data  in  64: write data.
- mmio_rsp_valid  out  1: read response valid.
- mmio_rsp_tid  out  9: echoed tid.
- mmio_rsp_data  out  64: read data.
- mapped_data_valid  out  1: FIFO head valid.
- mapped_data_ready  in  1: FPU accepts head.
- mapped_data  out  MAP_DATA_WIDTH: head data.
- mapped_address  out  MAP_ADDR_WIDTH: head register index.
- reg_q  out  64*NUM_REGS: flattened user registers; reg i occupies bits [64i+63:64i].

Behaviour:
- Reset (async on rst_n low): all outputs 0, user regs 0, FIFO empty, drop_cnt 0, read pipeline flushed. In-flight reads are discarded and produce no response. Release is synchronous to clk.
- Register map (word addresses):
  - 0x0 DFH, RO = 64'h1000_0100_0000_0000 (type AFU, end-of-list).
  - 0x2 AFU_ID[63:0], RO.
  - 0x4 AFU_ID[127:64], RO.
  - 0x6 and 0x8: RO, read 0.
  - 0xA STATUS: [15:0] drop_cnt, [23:16] FIFO occupancy, rest 0. Any write clears drop_cnt.
  - USER_BASE+2i, i<NUM_REGS: user reg i, RW.
  - Any other address: reads return 0, writes are ignored.
- 8B access: addr[0] must be 0; if addr[0]=1, the access is treated as unmapped.
- 4B access: addr[0] selects the half (0 = [31:0], 1 = [63:32]).
  - A 4B write updates only that half.
  - A 4B read returns the half in rsp_data[31:0], with [63:32]=0.
- Illegal mmio_len: a read responds 0; a write is ignored with no push.
- Reads: fixed 2-cycle latency. rd_valid at cycle N gives rsp_valid/tid/data at N+2, with rsp_valid high for exactly one cycle. Back-to-back reads every cycle are fully pipelined; responses are in order.
- Same-cycle read and write to the same register: the read returns the pre-write value.
- Writes: the register updates at the clk edge following wr_valid.
- Push on every legal write to a user reg:
  - Push occurs one cycle after wr_valid.
  - Entry = {index i, new 64-bit reg value truncated to MAP_DATA_WIDTH}.
  - mapped_address is i zero-extended to MAP_ADDR_WIDTH.
- FIFO:
  - Pop when mapped_data_valid && mapped_data_ready.
  - Outputs come directly from the head; valid is high iff occupancy > 0.
  - Push and pop in the same cycle while full: both are accepted, occupancy unchanged.
  - Push while full with no pop: the register still updates, the entry is dropped, and drop_cnt increments, saturating at 16'hFFFF.
  - A STATUS write coinciding with a drop clears drop_cnt to 0; the clear wins.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. The occupancy counter is log2(FIFO_DEPTH)+1 bits.

Test Plan:
- Reset, then read 0x0 (tid 9'h05) -> rsp_valid 2 cycles later, data 64'h1000_0100_0000_0000, tid 9'h05. Read 0x2/0x4 with AFU_ID=128'hAAAA...5555 -> the respective halves.
- 8B write 64'hDEAD_BEEF_0123_4567 to 0x12 (reg 1), then 8B read 0x12 -> DEADBEEF01234567. FIFO head is address 1, data 32'h0123_4567. With ready=1 -> one-cycle valid pulse.
- 4B write 32'hCAFE_F00D to 0x13 -> reg1 = 64'hCAFE_F00D_0123_4567. 4B read 0x12 -> rsp_data 64'h0000_0000_0123_4567.
- Hold ready=0, issue 6 writes with FIFO_DEPTH=4 -> STATUS reads occupancy 4, drop_cnt 2. Raise ready -> 4 entries drain in order. Write STATUS -> drop_cnt 0.
- Reads at 4 consecutive cycles (tids 1..4, including unmapped 0x40) -> 4 consecutive responses in order; 0x40 returns 0.
- Read issued, then rst_n low for 1 cycle before the response -> no rsp_valid; all regs 0 after release.
